load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage responder to the decoder's data-memory controls (`dmem_rd`, `dmem_wr`, `ld_st_funct3`) on the RV32I core. It turns one load or store request into a single word-aligned req/ack transaction on the data-memory bus, using byte enables for stores. It formats load data as byte, half or word, with sign or zero extension. It stalls the pipeline until the transaction completes and flags misaligned or illegal accesses without touching memory.

## Interface
Parameters:
- `NB_WORD`, 32: data/address width (from `riscv_defs`)
- `NB_BE`, `NB_WORD/8`: byte-enable width

Ports:
- `i_clock`  in  1  single clock; all state updates on its rising edge
- `i_reset`  in  1  asynchronous, active-high reset
- `i_dmem_rd`  in  1  load request from control bus
- `i_dmem_wr`  in  1  store request from control bus
- `i_ld_st_funct3`  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- `i_addr`  in  NB_WORD  effective address (ALU result)
- `i_store_data`  in  NB_WORD  rs2 value for stores
- `o_stall`  out  1  hold upstream pipeline registers
- `o_load_data`  out  NB_WORD  formatted load result, valid when `o_load_valid`
- `o_load_valid`  out  1  one-cycle pulse with load result
- `o_access_fault`  out  1  one-cycle pulse: misaligned or illegal access, no memory cycle
- `o_mem_req`  out  1  bus request, held until ack
- `o_mem_we`  out  1  1 for a store
- `o_mem_addr`  out  NB_WORD  word-aligned address, `i_addr[NB_WORD-1:2]` followed by 2'b00
- `o_mem_be`  out  NB_BE  store byte enables (4'b1111 on loads)
- `o_mem_wdata`  out  NB_WORD  lane-replicated store data
- `i_mem_ack`  in  1  bus completion; `i_mem_rdata` valid in the same cycle
- `i_mem_rdata`  in  NB_WORD  read word

## Operation
- FSM states are `IDLE`, `WAIT` and `RESP`.
- **IDLE, valid access** (exactly one of rd/wr, legal funct3, aligned):
  - capture addr, funct3, formatted wdata/be and the load/store flag
  - assert `o_stall` combinationally
  - go to `WAIT`
- **IDLE, fault:** an access is a fault when any of these holds:
  - rd and wr both set
  - store funct3 is greater than 010
  - load funct3 is 011, 110 or 111
  - H/HU with `addr[0]` = 1
  - W with `addr[1:0]` not 00

  On a fault: pulse `o_access_fault` the next cycle, no stall, stay in `IDLE`.
- **WAIT:**
  - `o_mem_req` = 1 and all bus outputs stable from registers
  - `o_stall` = 1
  - on `i_mem_ack`: latch the formatted load data and go to `RESP`
- **RESP:**
  - `o_stall` = 0
  - `o_load_valid` = 1 for loads only
  - rd/wr inputs ignored, because they still belong to the completing instruction
  - go to `IDLE`
- **Store formatting:**
  - SB: be = 4'b0001 shifted left by `addr[1:0]`; wdata = byte replicated ×4
  - SH: be = 4'b0011 shifted left by 2·`addr[1]`; wdata = half replicated ×2
  - SW: be = 4'b1111
- **Load formatting:**
  - select the lane by `addr[1:0]` (byte) or `addr[1]` (half)
  - B/H sign-extend from the selected lane's MSB; BU/HU zero-extend
- **Reset:**
  - all outputs 0, state `IDLE`
  - reset during `WAIT` drops `o_mem_req` immediately (async); the in-flight transaction is abandoned
  - an ack arriving after reset release in `IDLE` is ignored

## Timing
- A legal access takes 2 + N stall cycles, where N = cycles from the first `o_mem_req` to `i_mem_ack` (N ≥ 0).
  - With ack in the first `WAIT` cycle: cycle 0 `IDLE` (stall), cycle 1 `WAIT` (req, ack, stall), cycle 2 `RESP` (valid, no stall).
- `o_mem_*` change only on entry to `WAIT`; they are held constant while req=1 and ack=0.
- `o_mem_req` deasserts in the cycle after ack.
- `o_load_data` holds its value until the next load completes.
- A fault costs zero stall cycles; `o_access_fault` rises one cycle after the request.
- Back-to-back accesses: a new access is accepted in the `IDLE` cycle immediately following `RESP`.

## Structure
- `riscv_defs` gains:
  - `lsu_state_t` enum {IDLE, WAIT, RESP}
  - funct3 constants `LS_B`, `LS_H`, `LS_W`, `LS_BU`, `LS_HU`
  - `NB_BE`
- One combinational sub-module, `lsu_align`, holds the store lane replication, byte-enable generation, load extraction/extension and the fault check. `load_store_unit` holds the FSM and registers.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ack after 2 cycles -> `o_mem_addr` 0x100, be 1111, we 1, wdata 0xDEADBEEF; stall for 4 cycles, then `RESP`.
- SB addr 0x203, data 0x000000A5 -> addr 0x200, be 1000, wdata 0xA5A5A5A5.
- LB addr 0x301, rdata 0x1234_80FF, ack immediate -> `o_load_data` 0xFFFFFF80 with `o_load_valid` pulse; LBU same -> 0x00000080.
- LHU addr 0x402, rdata 0xBEEF_0000 -> 0x0000BEEF; LH -> 0xFFFFBEEF.
- LW addr 0x502 and LH addr 0x501 -> `o_access_fault` pulse, `o_mem_req` never rises, `o_stall` stays 0; funct3 011 load -> fault.
- Store in `WAIT` with ack withheld, `i_reset` pulsed -> `o_mem_req`/`o_stall` drop asynchronously; a late ack produces no `o_load_valid`.

Source files
------------

// File: rtl/riscv_defs.sv
// Shared RV32I core definitions.
// Word geometry, load/store size codes and LSU state encoding.
package riscv_defs;

  localparam int NB_WORD = 32;
  localparam int NB_BE   = NB_WORD / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Load/store lane alignment and access legality check.
// Purely combinational; request side and response side are independent.
module lsu_align #(
  parameter int NB_WORD = riscv_defs::NB_WORD,
  parameter int NB_BE   = NB_WORD / 8
) (
  input  logic               i_rd,
  input  logic               i_wr,
  input  logic [2:0]         i_funct3,
  input  logic [1:0]         i_offset,
  input  logic [NB_WORD-1:0] i_store_data,
  input  logic [2:0]         i_ld_funct3,
  input  logic [1:0]         i_ld_offset,
  input  logic [NB_WORD-1:0] i_rdata,
  output logic               o_fault,
  output logic               o_valid,
  output logic [NB_BE-1:0]   o_be,
  output logic [NB_WORD-1:0] o_wdata,
  output logic [NB_WORD-1:0] o_rdata_fmt
);

  import riscv_defs::*;

  logic               ld_ok;
  logic               st_ok;
  logic               mis;
  logic [NB_WORD-1:0] b_sh;
  logic [NB_WORD-1:0] h_sh;
  logic [7:0]         b_lane;
  logic [15:0]        h_lane;

  // Legality: size code must exist for the direction, and H/W must be aligned.
  always_comb begin
    ld_ok = (i_funct3 == LS_B) || (i_funct3 == LS_H) ||
            (i_funct3 == LS_W) || (i_funct3 == LS_BU) ||
            (i_funct3 == LS_HU);
    st_ok = (i_funct3 == LS_B) || (i_funct3 == LS_H) ||
            (i_funct3 == LS_W);
    mis   = ((i_funct3[1:0] == 2'b01) && i_offset[0]) ||
            ((i_funct3[1:0] == 2'b10) && (i_offset != 2'b00));
    o_fault = (i_rd && i_wr) ||
              (i_rd && !i_wr && (!ld_ok || mis)) ||
              (i_wr && !i_rd && (!st_ok || mis));
    o_valid = (i_rd ^ i_wr) && !o_fault;
  end

  // Store lanes: replicate data across the word, enable only the target bytes.
  always_comb begin
    o_be    = '1;
    o_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = NB_BE'(1) << i_offset;
        o_wdata = {NB_BE{i_store_data[7:0]}};
      end
      2'b01: begin
        o_be    = NB_BE'(3) << {i_offset[1], 1'b0};
        o_wdata = {(NB_BE/2){i_store_data[15:0]}};
      end
      default: begin
        o_be    = '1;
        o_wdata = i_store_data;
      end
    endcase
  end

  // Load lanes: pick byte/half from the read word, then extend.
  always_comb begin
    b_sh   = i_rdata >> {i_ld_offset, 3'b000};
    h_sh   = i_rdata >> {i_ld_offset[1], 4'b0000};
    b_lane = b_sh[7:0];
    h_lane = h_sh[15:0];
    case (i_ld_funct3)
      LS_B:    o_rdata_fmt = {{(NB_WORD-8){b_lane[7]}}, b_lane};
      LS_BU:   o_rdata_fmt = {{(NB_WORD-8){1'b0}}, b_lane};
      LS_H:    o_rdata_fmt = {{(NB_WORD-16){h_lane[15]}}, h_lane};
      LS_HU:   o_rdata_fmt = {{(NB_WORD-16){1'b0}}, h_lane};
      default: o_rdata_fmt = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one word-aligned req/ack bus cycle per access.
// Stalls the pipeline until the cycle completes; faults never reach the bus.
module load_store_unit #(
  parameter int NB_WORD = riscv_defs::NB_WORD,
  parameter int NB_BE   = NB_WORD / 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_dmem_rd,
  input  logic               i_dmem_wr,
  input  logic [2:0]         i_ld_st_funct3,
  input  logic [NB_WORD-1:0] i_addr,
  input  logic [NB_WORD-1:0] i_store_data,
  output logic               o_stall,
  output logic [NB_WORD-1:0] o_load_data,
  output logic               o_load_valid,
  output logic               o_access_fault,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [NB_WORD-1:0] o_mem_addr,
  output logic [NB_BE-1:0]   o_mem_be,
  output logic [NB_WORD-1:0] o_mem_wdata,
  input  logic               i_mem_ack,
  input  logic [NB_WORD-1:0] i_mem_rdata
);

  import riscv_defs::*;

  lsu_state_t         state_q, state_d;
  logic [NB_WORD-1:0] addr_q, addr_d;
  logic [NB_WORD-1:0] wdata_q, wdata_d;
  logic [NB_WORD-1:0] ld_data_q, ld_data_d;
  logic [NB_BE-1:0]   be_q, be_d;
  logic               we_q, we_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         off_q, off_d;
  logic               fault_q, fault_d;

  logic               acc_fault;
  logic               acc_valid;
  logic [NB_BE-1:0]   fmt_be;
  logic [NB_WORD-1:0] fmt_wdata;
  logic [NB_WORD-1:0] fmt_rdata;

  lsu_align #(
    .NB_WORD (NB_WORD),
    .NB_BE   (NB_BE)
  ) u_align (
    .i_rd         (i_dmem_rd),
    .i_wr         (i_dmem_wr),
    .i_funct3     (i_ld_st_funct3),
    .i_offset     (i_addr[1:0]),
    .i_store_data (i_store_data),
    .i_ld_funct3  (f3_q),
    .i_ld_offset  (off_q),
    .i_rdata      (i_mem_rdata),
    .o_fault      (acc_fault),
    .o_valid      (acc_valid),
    .o_be         (fmt_be),
    .o_wdata      (fmt_wdata),
    .o_rdata_fmt  (fmt_rdata)
  );

  // Next-state: accept in IDLE, wait for ack, one response cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ld_data_d = ld_data_q;
    be_d      = be_q;
    we_d      = we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    fault_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        fault_d = acc_fault;
        if (acc_valid) begin
          addr_d  = {i_addr[NB_WORD-1:2], 2'b00};
          off_d   = i_addr[1:0];
          f3_d    = i_ld_st_funct3;
          we_d    = i_dmem_wr;
          be_d    = i_dmem_wr ? fmt_be : '1;
          wdata_d = i_dmem_wr ? fmt_wdata : '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_mem_ack) begin
          if (!we_q) ld_data_d = fmt_rdata;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured bus/response registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      ld_data_q <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ld_data_q <= ld_data_d;
      be_q      <= be_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      fault_q   <= fault_d;
    end
  end

  // Outputs; stall is forced low while reset is held.
  always_comb begin
    o_stall        = !i_reset &&
                     (((state_q == IDLE) && acc_valid) ||
                      (state_q == WAIT));
    o_mem_req      = (state_q == WAIT);
    o_load_valid   = (state_q == RESP) && !we_q;
    o_access_fault = fault_q;
    o_load_data    = ld_data_q;
    o_mem_we       = we_q;
    o_mem_addr     = addr_q;
    o_mem_be       = be_q;
    o_mem_wdata    = wdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// Transaction-level expectations, checked every cycle on the falling edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_dmem_rd, i_dmem_wr;
  logic [2:0]  i_ld_st_funct3;
  logic [31:0] i_addr, i_store_data;
  logic        o_stall, o_load_valid, o_access_fault;
  logic [31:0] o_load_data;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  int stall_cnt;
  bit chk_en = 1'b0;

  bit          exp_stall, exp_req, exp_we, exp_lv, exp_fault;
  bit          chk_wd;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_be;

  load_store_unit dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_dmem_rd      (i_dmem_rd),
    .i_dmem_wr      (i_dmem_wr),
    .i_ld_st_funct3 (i_ld_st_funct3),
    .i_addr         (i_addr),
    .i_store_data   (i_store_data),
    .o_stall        (o_stall),
    .o_load_data    (o_load_data),
    .o_load_valid   (o_load_valid),
    .o_access_fault (o_access_fault),
    .o_mem_req      (o_mem_req),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_be       (o_mem_be),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_ack      (i_mem_ack),
    .i_mem_rdata    (i_mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic bit m_fault(bit rd, bit wr, logic [2:0] f3,
                                 logic [31:0] a);
    int sz;
    sz = int'(f3[1:0]);
    if (rd && wr) return 1;
    if (wr && f3 > 3'd2) return 1;
    if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1;
    if (sz == 1 && a[0]) return 1;
    if (sz == 2 && a[1:0] != 2'b00) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return 4'(3 << (2 * (off / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] d);
    if (f3 == 3'd0) return {4{d[7:0]}};
    if (f3 == 3'd1) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a,
                                         logic [31:0] w);
    int          off;
    logic [7:0]  b;
    logic [15:0] h;
    off = int'(a[1:0]);
    b = 8'(w >> (8 * off));
    h = 16'(w >> (16 * (off / 2)));
    case (f3)
      3'd0: return 32'($signed(b));
      3'd4: return 32'(b);
      3'd1: return 32'($signed(h));
      3'd5: return 32'(h);
      default: return w;
    endcase
  endfunction

  // Per-cycle comparison against the expected bus/pipeline view.
  always @(negedge clk) begin
    if (chk_en) begin
      if (o_stall) stall_cnt++;
      chk("stall", 32'(o_stall), 32'(exp_stall));
      chk("mem_req", 32'(o_mem_req), 32'(exp_req));
      chk("mem_we", 32'(o_mem_we), 32'(exp_we));
      chk("mem_addr", o_mem_addr, exp_addr);
      chk("mem_be", 32'(o_mem_be), 32'(exp_be));
      if (chk_wd) chk("mem_wdata", o_mem_wdata, exp_wdata);
      chk("load_valid", 32'(o_load_valid), 32'(exp_lv));
      chk("load_data", o_load_data, exp_ld);
      chk("access_fault", 32'(o_access_fault), 32'(exp_fault));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdat, input int nack);
    bit flt;
    i_dmem_rd = rd;
    i_dmem_wr = wr;
    i_ld_st_funct3 = f3;
    i_addr = a;
    i_store_data = sd;
    i_mem_rdata = rdat;
    flt = m_fault(rd, wr, f3, a);
    exp_stall = !flt;
    exp_req = 0;
    exp_lv = 0;
    exp_fault = 0;
    step();
    if (flt) begin
      i_dmem_rd = 0;
      i_dmem_wr = 0;
      exp_fault = 1;
      step();
      exp_fault = 0;
      return;
    end
    exp_req = 1;
    exp_addr = {a[31:2], 2'b00};
    exp_we = wr;
    exp_be = wr ? m_be(f3, a) : 4'hF;
    exp_wdata = m_wdata(f3, sd);
    chk_wd = wr;
    for (int k = 0; k <= nack; k++) begin
      i_mem_ack = (k == nack);
      step();
    end
    i_mem_ack = 0;
    exp_req = 0;
    exp_stall = 0;
    exp_lv = rd;
    if (rd) exp_ld = m_load(f3, a, rdat);
    step();
    i_dmem_rd = 0;
    i_dmem_wr = 0;
    exp_lv = 0;
  endtask

  initial begin
    i_reset = 1;
    i_dmem_rd = 0;
    i_dmem_wr = 0;
    i_ld_st_funct3 = 0;
    i_addr = 0;
    i_store_data = 0;
    i_mem_ack = 0;
    i_mem_rdata = 0;
    {exp_stall, exp_req, exp_we, exp_lv, exp_fault} = '0;
    exp_addr = 0;
    exp_wdata = 0;
    exp_ld = 0;
    exp_be = 0;
    chk_wd = 1;
    stall_cnt = 0;
    #3;
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_be", 32'(o_mem_be), 32'd0);
    chk("rst_ld", o_load_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    i_reset = 0;
    chk_en = 1;
    step();

    stall_cnt = 0;
    access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 2);
    chk("sw_stall_cycles", stall_cnt, 32'd4);
    chk("sw_addr", o_mem_addr, 32'h100);
    chk("sw_be", 32'(o_mem_be), 32'hF);
    chk("sw_wdata", o_mem_wdata, 32'hDEADBEEF);

    access(0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 0);
    chk("sb_addr", o_mem_addr, 32'h200);
    chk("sb_be", 32'(o_mem_be), 32'h8);
    chk("sb_wdata", o_mem_wdata, 32'hA5A5A5A5);

    access(0, 1, 3'b001, 32'h202, 32'h1234BEEF, 0, 1);
    chk("sh_be", 32'(o_mem_be), 32'hC);
    chk("sh_wdata", o_mem_wdata, 32'hBEEFBEEF);

    stall_cnt = 0;
    access(1, 0, 3'b000, 32'h301, 0, 32'h123480FF, 0);
    chk("lb_stall_cycles", stall_cnt, 32'd2);
    chk("lb_data", o_load_data, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h301, 0, 32'h123480FF, 0);
    chk("lbu_data", o_load_data, 32'h00000080);
    step();

    access(1, 0, 3'b101, 32'h402, 0, 32'hBEEF0000, 1);
    chk("lhu_data", o_load_data, 32'h0000BEEF);
    access(1, 0, 3'b001, 32'h402, 0, 32'hBEEF0000, 0);
    chk("lh_data", o_load_data, 32'hFFFFBEEF);
    step();

    stall_cnt = 0;
    access(1, 0, 3'b010, 32'h502, 0, 0, 0);
    access(1, 0, 3'b001, 32'h501, 0, 0, 0);
    access(1, 0, 3'b011, 32'h500, 0, 0, 0);
    access(0, 1, 3'b100, 32'h500, 32'h11, 0, 0);
    access(1, 1, 3'b010, 32'h500, 32'h22, 0, 0);
    chk("fault_stall_cycles", stall_cnt, 32'd0);
    chk("fault_ld_hold", o_load_data, 32'hFFFFBEEF);

    access(1, 0, 3'b010, 32'h504, 0, 32'hCAFEF00D, 3);
    chk("lw_data", o_load_data, 32'hCAFEF00D);
    step();

    i_dmem_wr = 1;
    i_ld_st_funct3 = 3'b010;
    i_addr = 32'h600;
    i_store_data = 32'h55AA55AA;
    exp_stall = 1;
    step();
    exp_req = 1;
    exp_we = 1;
    exp_addr = 32'h600;
    exp_be = 4'hF;
    exp_wdata = 32'h55AA55AA;
    chk_wd = 1;
    step();
    #2;
    chk_en = 0;
    i_reset = 1;
    #1;
    chk("arst_req", 32'(o_mem_req), 32'd0);
    chk("arst_stall", 32'(o_stall), 32'd0);
    chk("arst_be", 32'(o_mem_be), 32'd0);
    i_dmem_wr = 0;
    {exp_stall, exp_req, exp_we, exp_lv, exp_fault} = '0;
    exp_addr = 0;
    exp_be = 0;
    exp_wdata = 0;
    exp_ld = 0;
    step();
    i_reset = 0;
    chk_en = 1;
    i_mem_ack = 1;
    i_mem_rdata = 32'h87654321;
    step();
    i_mem_ack = 0;
    step();
    step();
    chk("late_ack_ld", o_load_data, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
